hamming_encoder: RTL and testbench

HAMMING_ENCODER -- requirements
Module: hamming_encoder

---
 rtl/hamming_pkg.sv | 26 ++
 rtl/hamming_parity_gen.sv | 22 ++
 rtl/hamming_encoder.sv | 142 ++++++++++++++
 tb/tb_hamming_encoder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared constants and types for the Hamming(7,4) encoder.
// Codeword bit indices are 0-based; positional weights are index+1.
package hamming_pkg;

    localparam int DATA_W = 4;
    localparam int CODE_W = 7;

    // Parity bit locations within the codeword.
    localparam int P1_POS = 0;
    localparam int P2_POS = 1;
    localparam int P4_POS = 3;

    // Data bit locations within the codeword.
    localparam int D0_POS = 2;
    localparam int D1_POS = 4;
    localparam int D2_POS = 5;
    localparam int D3_POS = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENCODE  = 2'd1,
        ST_SEND    = 2'd2,
        ST_BACKOFF = 2'd3
    } state_t;

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational Hamming(7,4) codeword builder: places data bits and
// computes the three even-parity bits.
module hamming_parity_gen
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CODE_W-1:0] code
);

    // Scatter data bits and compute parity over their covered positions.
    always_comb begin
        code         = '0;
        code[D0_POS] = data[0];
        code[D1_POS] = data[1];
        code[D2_POS] = data[2];
        code[D3_POS] = data[3];
        code[P1_POS] = data[0] ^ data[1] ^ data[3];
        code[P2_POS] = data[0] ^ data[2] ^ data[3];
        code[P4_POS] = data[1] ^ data[2] ^ data[3];
    end

endmodule

// File: rtl/hamming_encoder.sv
// Hamming(7,4) encoder with a fixed forward latency (FL) and a post-send
// backoff (BL). One word in flight at a time.
// Optional build macro HAM_ERR_INJECT_EN adds inj_en/inj_pos, which flip
// one bit of the registered codeword at accept time.
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_IDLE    | in_ready=1, waiting for a word
// ST_ENCODE  | counting down FL cycles before presenting output
// ST_SEND    | out_valid=1, holding codeword until out_ready
// ST_BACKOFF | counting down BL cycles before accepting again
module hamming_encoder
    import hamming_pkg::*;
#(
    parameter int FL = 4,
    parameter int BL = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_data,
`ifdef HAM_ERR_INJECT_EN
    input  logic              inj_en,
    input  logic [2:0]        inj_pos,
`endif
    output logic [7:0]        sent_count
);

    localparam logic [3:0] FL_CNT = 4'(FL);
    localparam logic [3:0] BL_CNT = 4'(BL);

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          count;
    logic [3:0]          count_nxt;
    logic [CODE_W-1:0]   code_gen;
    logic [CODE_W-1:0]   code_load;
    logic [CODE_W-1:0]   code_q;
    logic [7:0]          sent_q;
    logic                accept;
    logic                handshake;

    hamming_parity_gen u_parity_gen (
        .data (in_data),
        .code (code_gen)
    );

`ifdef HAM_ERR_INJECT_EN
    // Optionally invert one codeword bit (1-based position) before it is stored.
    always_comb begin
        code_load = code_gen;
        if (inj_en && (inj_pos != 3'd0)) begin
            code_load[inj_pos - 3'd1] = ~code_gen[inj_pos - 3'd1];
        end
    end
`else
    assign code_load = code_gen;
`endif

    // Reset masks in_ready so nothing can look acceptable during reset.
    assign in_ready   = (state == ST_IDLE) && !reset;
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state == ST_SEND);
    assign handshake  = out_valid && out_ready;
    assign out_data   = code_q;
    assign sent_count = sent_q;

    // Next-state and down-counter logic; terminal count is 1 so a phase of N
    // cycles is loaded with N.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (FL_CNT == 4'd0) begin
                        state_nxt = ST_SEND;
                        count_nxt = 4'd0;
                    end else begin
                        state_nxt = ST_ENCODE;
                        count_nxt = FL_CNT;
                    end
                end
            end
            ST_ENCODE: begin
                if (count <= 4'd1) begin
                    state_nxt = ST_SEND;
                    count_nxt = 4'd0;
                end else begin
                    count_nxt = count - 4'd1;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (BL_CNT == 4'd0) begin
                        state_nxt = ST_IDLE;
                        count_nxt = 4'd0;
                    end else begin
                        state_nxt = ST_BACKOFF;
                        count_nxt = BL_CNT;
                    end
                end
            end
            ST_BACKOFF: begin
                if (count <= 4'd1) begin
                    state_nxt = ST_IDLE;
                    count_nxt = 4'd0;
                end else begin
                    count_nxt = count - 4'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                count_nxt = 4'd0;
            end
        endcase
    end

    // State, counter, codeword and handshake counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            count  <= 4'd0;
            code_q <= '0;
            sent_q <= 8'd0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (accept) begin
                code_q <= code_load;
            end
            if (handshake) begin
                sent_q <= sent_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_encoder.sv
// Self-checking bench for hamming_encoder (FL=4, BL=6 defaults).
// Expected codewords come from a positional Hamming model, not the RTL layout.
module tb_hamming_encoder;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_data;
    logic [7:0] sent_count;
`ifdef HAM_ERR_INJECT_EN
    logic       inj_en;
    logic [2:0] inj_pos;
`endif

    int checks = 0;
    int errors = 0;
    int sc_model = 0;

    hamming_encoder #(.FL(4), .BL(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
`ifdef HAM_ERR_INJECT_EN
        .inj_en     (inj_en),
        .inj_pos    (inj_pos),
`endif
        .sent_count (sent_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        logic [6:0] code;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Positional Hamming: data fills non-power-of-two positions 3,5,6,7 in
    // order; parity at position p covers every position whose index has bit p.
    function automatic logic [6:0] ref_code(input logic [3:0] d);
        logic [6:0] c;
        int k;
        c = '0;
        k = 0;
        for (int pos = 1; pos <= 7; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = d[k];
                k++;
            end
        end
        for (int p = 1; p <= 4; p = p * 2) begin
            logic x;
            x = 1'b0;
            for (int q = 1; q <= 7; q++) begin
                if (((q & p) != 0) && (q != p)) x = x ^ c[q-1];
            end
            c[p-1] = x;
        end
        return c;
    endfunction

    function automatic int syndrome(input logic [6:0] c);
        int s;
        s = 0;
        for (int p = 1; p <= 4; p = p * 2) begin
            logic x;
            x = 1'b0;
            for (int q = 1; q <= 7; q++) begin
                if ((q & p) != 0) x = x ^ c[q-1];
            end
            if (x) s = s | p;
        end
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("in_ready_during_reset", int'(in_ready), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        sc_model = 0;
    endtask

    // Offer one word and follow it until in_ready returns (out_ready assumed 1).
    // lat: cycles from accept edge to first out_valid; busy: cycles in_ready low.
    task automatic xfer(input logic [3:0] d, output logic [6:0] code,
                        output int lat, output int busy);
        int t;
        int n;
        bit done;
        code = '0;
        lat  = 0;
        busy = -1;
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("accept_timeout", 1, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_data = 4'h0;
        n = 1;
        done = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            if (out_valid && lat == 0) begin
                lat  = n;
                code = out_data;
                if (out_ready) sc_model = (sc_model + 1) % 256;
            end
            if (in_ready) begin
                busy = n - 1;
                done = 1'b1;
            end else begin
                n++;
            end
        end
    endtask

    vec_t       vecs[7];
    logic [6:0] code;
    logic [6:0] held;
    int         lat;
    int         busy;
    int         bad;
    int         seen;
    logic [3:0] rd;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        out_ready = 1'b1;
`ifdef HAM_ERR_INJECT_EN
        inj_en    = 1'b0;
        inj_pos   = 3'd0;
`endif

        vecs[0] = '{data: 4'h0, code: 7'h00};
        vecs[1] = '{data: 4'hF, code: 7'h7F};
        vecs[2] = '{data: 4'h1, code: 7'h07};
        vecs[3] = '{data: 4'hB, code: 7'h55};
        vecs[4] = '{data: 4'h2, code: 7'h19};
        vecs[5] = '{data: 4'h4, code: 7'h2A};
        vecs[6] = '{data: 4'h8, code: 7'h4B};

        // Reset state.
        do_reset();
        @(negedge clk);
        chk("in_ready_after_reset", int'(in_ready), 1);
        chk("out_valid_after_reset", int'(out_valid), 0);
        chk("out_data_after_reset", int'(out_data), 0);
        chk("sent_count_after_reset", int'(sent_count), 0);

        // Directed vector table: codeword, latency FL+1, busy FL+1+BL.
        for (int i = 0; i < 7; i++) begin
            xfer(vecs[i].data, code, lat, busy);
            chk($sformatf("vec%0d_code", i), int'(code), int'(vecs[i].code));
            chk($sformatf("vec%0d_latency", i), lat, 5);
            chk($sformatf("vec%0d_busy", i), busy, 11);
        end
        chk("sent_count_after_table", int'(sent_count), sc_model);

        // All 16 nibbles then random nibbles against the reference model.
        for (int i = 0; i < 26; i++) begin
            rd = (i < 16) ? 4'(i) : 4'($urandom_range(0, 15));
            xfer(rd, code, lat, busy);
            chk($sformatf("rand%0d_code_d%0h", i, rd), int'(code), int'(ref_code(rd)));
            chk($sformatf("rand%0d_syndrome", i), syndrome(code), 0);
        end
        chk("sent_count_after_random", int'(sent_count), sc_model);

        // Backpressure: hold out_ready low 20 cycles in SEND with in_valid high.
        @(negedge clk);
        out_ready = 1'b0;
        in_data   = 4'h6;
        in_valid  = 1'b1;
        seen = 0;
        while (!in_ready && seen < 50) begin @(negedge clk); seen++; end
        @(posedge clk);
        #1 in_data = 4'h9;
        seen = 0;
        @(negedge clk);
        while (!out_valid && seen < 50) begin @(negedge clk); seen++; end
        chk("stall_reached_send", int'(out_valid), 1);
        held = out_data;
        chk("stall_code", int'(held), int'(ref_code(4'h6)));
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!out_valid || out_data != held || in_ready) bad++;
        end
        chk("stall_hold_violations", bad, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        sc_model = (sc_model + 1) % 256;
        @(negedge clk);
        chk("stall_released", int'(out_valid), 0);
        chk("sent_count_after_stall", int'(sent_count), sc_model);
        repeat (8) @(negedge clk);
        chk("stall_idle_again", int'(in_ready), 1);

        // Reset during the second ENCODE cycle discards the word.
        @(negedge clk);
        in_data  = 4'hB;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        sc_model = 0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid || out_data != 7'h00) seen++;
        end
        chk("reset_discard_no_output", seen, 0);
        chk("reset_discard_sent_count", int'(sent_count), 0);
        chk("reset_discard_in_ready", int'(in_ready), 1);

`ifdef HAM_ERR_INJECT_EN
        inj_en  = 1'b1;
        inj_pos = 3'd3;
        xfer(4'hB, code, lat, busy);
        chk("inject_pos3", int'(code), 'h51);
        inj_pos = 3'd0;
        xfer(4'hB, code, lat, busy);
        chk("inject_pos0", int'(code), 'h55);
        inj_pos = 3'd7;
        xfer(4'h0, code, lat, busy);
        chk("inject_pos7", int'(code), 'h40);
        inj_en = 1'b0;
        xfer(4'hB, code, lat, busy);
        chk("inject_disabled", int'(code), 'h55);
`endif

        // 257 back-to-back words: sent_count wraps to 1.
        do_reset();
        bad = 0;
        for (int i = 0; i < 257; i++) begin
            rd = 4'($urandom_range(0, 15));
            xfer(rd, code, lat, busy);
            if (code != ref_code(rd) || busy != 11) bad++;
        end
        chk("wrap_word_errors", bad, 0);
        chk("wrap_sent_count", int'(sent_count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
